// File: rtl/systolic_feeder_3by3.sv
// Buffers one 3x3 A and one 3x3 B matrix and streams them as skewed
// diagonal wavefronts into a 3x3 systolic array, then drains and pulses done.
module systolic_feeder_3by3 #(
  parameter int DATA_W       = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [1:0]        wr_row,
  input  logic [1:0]        wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [DATA_W-1:0] a_out_0,
  output logic [DATA_W-1:0] a_out_1,
  output logic [DATA_W-1:0] a_out_2,
  output logic [DATA_W-1:0] b_out_0,
  output logic [DATA_W-1:0] b_out_1,
  output logic [DATA_W-1:0] b_out_2
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0] t_q, t_d;
  logic [3:0] dr_q, dr_d;
  logic       load;
  logic [2:0] tn;

  logic [DATA_W-1:0] a_q [3][3];
  logic [DATA_W-1:0] a_d [3][3];
  logic [DATA_W-1:0] b_q [3][3];
  logic [DATA_W-1:0] b_d [3][3];
  logic [DATA_W-1:0] al_q [3];
  logic [DATA_W-1:0] al_d [3];
  logic [DATA_W-1:0] bl_q [3];
  logic [DATA_W-1:0] bl_d [3];

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    dr_d    = dr_q;
    a_d     = a_q;
    b_d     = b_q;
    load    = 1'b0;
    tn      = 3'd0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          t_d     = 3'd0;
          load    = 1'b1;
        end else if (wr_en && wr_row != 2'd3
                     && wr_col != 2'd3) begin
          if (wr_sel) b_d[wr_row][wr_col] = wr_data;
          else        a_d[wr_row][wr_col] = wr_data;
        end
      end
      STREAM: begin
        if (t_q == 3'd4) begin
          state_d = DRAIN;
          dr_d    = 4'd0;
        end else begin
          t_d  = t_q + 3'd1;
          tn   = t_q + 3'd1;
          load = 1'b1;
        end
      end
      DRAIN: begin
        if (dr_q == 4'(DRAIN_CYCLES - 1)) state_d = DONE;
        else dr_d = dr_q + 4'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Lane i carries element k of its row/column when t == i + k.
    for (int i = 0; i < 3; i++) begin
      al_d[i] = '0;
      bl_d[i] = '0;
      for (int k = 0; k < 3; k++) begin
        if (load && tn == 3'(i + k)) begin
          al_d[i] = a_q[i][k];
          bl_d[i] = b_q[k][i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      t_q     <= 3'd0;
      dr_q    <= 4'd0;
      for (int i = 0; i < 3; i++) begin
        al_q[i] <= '0;
        bl_q[i] <= '0;
        for (int k = 0; k < 3; k++) begin
          a_q[i][k] <= '0;
          b_q[i][k] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      dr_q    <= dr_d;
      al_q    <= al_d;
      bl_q    <= bl_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign busy    = (state_q == STREAM) || (state_q == DRAIN);
  assign valid   = (state_q == STREAM);
  assign done    = (state_q == DONE);
  assign a_out_0 = al_q[0];
  assign a_out_1 = al_q[1];
  assign a_out_2 = al_q[2];
  assign b_out_0 = bl_q[0];
  assign b_out_1 = bl_q[1];
  assign b_out_2 = bl_q[2];

endmodule

// File: doc/systolic_feeder_3by3.md
Name: systolic_feeder_3by3

Overview:
- Transmit-side companion to the 3x3 systolic multiply array.
- Buffers one 3x3 A matrix and one 3x3 B matrix written over a simple register-write port.
- On start, streams them as skewed, zero-padded diagonal wavefronts on six 8-bit lanes that drive the array's row and column inputs.
- Then holds zeros for a drain window and pulses done.

Parameters:
- DATA_W, 8, element width of matrix entries and output lanes.
- DRAIN_CYCLES, 4, zero-output cycles after the last stream step before done (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe for matrix storage.
- wr_sel  input  1  0 = write A, 1 = write B.
- wr_row  input  2  element row index (0..2).
- wr_col  input  2  element column index (0..2).
- wr_data  input  DATA_W  element value.
- start  input  1  begin streaming; sampled only in IDLE.
- busy  output  1  high in STREAM and DRAIN.
- done  output  1  one-cycle pulse at end of DRAIN.
- valid  output  1  high while lanes carry a stream step (t=0..4).
- a_out_0, a_out_1, a_out_2  output  DATA_W each  row lanes; lane i feeds array row i.
- b_out_0, b_out_1, b_out_2  output  DATA_W each  column lanes; lane j feeds array column j.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All 18 storage elements clear to 0.
  - All outputs clear to 0.
  - Step and drain counters clear.
  - Applies at any point, including mid-stream; no partial stream resumes after release.
- Storage writes:
  - In IDLE, when wr_en=1, start=0 and both indices are <=2, element [wr_row][wr_col] of the selected matrix takes wr_data at the clock edge.
  - Index value 3 is ignored.
  - Writes while busy=1 are ignored.
  - Writes in the same cycle as an accepted start are ignored; start has priority.
- FSM states: IDLE, STREAM, DRAIN, DONE.
  - IDLE to STREAM: on an edge with start=1. Step counter t becomes 0, and the lanes register the t=0 values at that same edge. First valid data is therefore visible in the cycle after start was sampled.
  - STREAM: t advances by 1 per edge, covering t=0..4 (5 cycles, valid=1). All lanes are registered outputs.
  - Lane schedule:
    - a_out_i at step t = A[i][t-i] when 0 <= t-i <= 2, else 0.
    - b_out_j at step t = B[t-j][j] when 0 <= t-j <= 2, else 0.
  - STREAM to DRAIN: on the edge after t=4. Lanes go to 0 and valid goes to 0. DRAIN lasts exactly DRAIN_CYCLES cycles with zero lanes.
  - DRAIN to DONE: DONE lasts 1 cycle with done=1 and busy=0.
  - DONE to IDLE: unconditional.
  - start in DONE is ignored.
- start while busy is ignored; it is not queued.
- Storage is not modified by streaming. A second start streams the same matrices again.
- Latency: from the start sample edge, done is high for the cycle 5 + DRAIN_CYCLES + 1 cycles later.
  - busy: 5 + DRAIN_CYCLES cycles.
- No arithmetic is performed; values pass through unchanged, with full DATA_W width.

Test Plan:
- Reset defaults: assert reset=0 mid-cycle with no clock edge -> all lanes, busy, done and valid are 0 immediately. After release, start with empty storage -> five valid cycles of all-zero lanes.
- Skew pattern: load A=[[1,2,3],[4,5,6],[7,8,9]], B=[[10,11,12],[13,14,15],[16,17,18]], pulse start -> per t:
  - t0: a=(1,0,0), b=(10,0,0)
  - t1: a=(2,4,0), b=(13,11,0)
  - t2: a=(3,5,7), b=(16,14,12)
  - t3: a=(0,6,8), b=(0,17,15)
  - t4: a=(0,0,9), b=(0,0,18)
  - Then 4 zero cycles with busy=1, then done for 1 cycle.
- Protocol guards:
  - Write A[0][0]=99 during STREAM -> ignored; a replay still shows 1.
  - start during DRAIN -> no restart; exactly one done pulse.
  - wr_en and start in the same cycle -> write is dropped.
- Index guard: wr_row=3, wr_data=55 -> no element changes (check via full stream dump).
- Reset mid-stream: drop reset at t=2 -> lanes are 0 at once, state is IDLE. After release, start streams all-zero data, since storage was cleared.
- Back-to-back: start asserted the cycle after done -> new stream begins with the correct t0 values and no stale lane data.
